// File: rtl/link_frame_rx_if.sv
// link_frame_rx_if: byte stream in, decoded game strobes and link status out.
interface link_frame_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [1:0] dir_out;
    logic       dir_valid;
    logic [5:0] seed_x;
    logic [5:0] seed_y;
    logic       seed_valid;
    logic       start_game;
    logic       frame_err;
    logic       con_error;
    logic [7:0] err_cnt;
    modport master (
        output rx_data, rx_valid,
        input  dir_out, dir_valid, seed_x, seed_y, seed_valid, start_game, frame_err, con_error, err_cnt
    );
    modport slave (
        input  rx_data, rx_valid,
        output dir_out, dir_valid, seed_x, seed_y, seed_valid, start_game, frame_err, con_error, err_cnt
    );
endinterface

// File: rtl/link_frame_rx.sv
// link_frame_rx: deframes SYNC,TYPE,P0,P1,CHK frames into direction/seed/start strobes.
// Define LINK_STATS_EN to count discarded frames on err_cnt (tied to zero otherwise).
module link_frame_rx #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         BYTE_TIMEOUT = 75_000,
    parameter int         LINK_TIMEOUT = 150_000_000
) (
    input logic            clk,
    input logic            rst,
    link_frame_rx_if.slave lnk
);
    localparam int BW = $clog2(BYTE_TIMEOUT);
    localparam int LW = $clog2(LINK_TIMEOUT);
    localparam logic [BW-1:0] BYTE_LAST = BW'(BYTE_TIMEOUT - 1);
    localparam logic [LW-1:0] LINK_LAST = LW'(LINK_TIMEOUT - 1);
    typedef enum logic [2:0] {S_IDLE, S_TYPE, S_P0, S_P1, S_CHK} state_t;
    state_t        state_q, state_d;
    logic [7:0]    type_q, type_d, p0_q, p0_d, p1_q, p1_d;
    logic [BW-1:0] byte_cnt_q, byte_cnt_d;
    logic [LW-1:0] link_cnt_q, link_cnt_d;
    logic [1:0]    dir_q, dir_d;
    logic [5:0]    seed_x_q, seed_x_d, seed_y_q, seed_y_d;
    logic          dir_valid_q, dir_valid_d, seed_valid_q, seed_valid_d;
    logic          start_q, start_d, frame_err_q, frame_err_d, con_error_q, con_error_d;
    logic          good, frame_ok;
    assign frame_ok = lnk.rx_data == (type_q ^ p0_q ^ p1_q) && type_q inside {8'h01, 8'h02, 8'h03};
    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        p0_d        = p0_q;
        p1_d        = p1_q;
        byte_cnt_d  = byte_cnt_q;
        good        = 1'b0;
        frame_err_d = 1'b0;
        if (lnk.rx_valid) begin
            byte_cnt_d = '0;
            case (state_q)
                S_IDLE: state_d = lnk.rx_data == SYNC_BYTE ? S_TYPE : S_IDLE;
                S_TYPE: begin
                    type_d  = lnk.rx_data;
                    state_d = S_P0;
                end
                S_P0: begin
                    p0_d    = lnk.rx_data;
                    state_d = S_P1;
                end
                S_P1: begin
                    p1_d    = lnk.rx_data;
                    state_d = S_CHK;
                end
                default: begin
                    state_d     = S_IDLE;
                    good        = frame_ok;
                    frame_err_d = !frame_ok;
                end
            endcase
        end else if (state_q != S_IDLE) begin
            // an arriving byte always beats the inter-byte timeout
            frame_err_d = byte_cnt_q == BYTE_LAST;
            byte_cnt_d  = frame_err_d ? '0 : byte_cnt_q + BW'(1);
            state_d     = frame_err_d ? S_IDLE : state_q;
        end
        dir_valid_d  = good && type_q == 8'h01;
        seed_valid_d = good && type_q == 8'h02;
        start_d      = good && type_q == 8'h03;
        dir_d        = dir_valid_d ? p0_q[1:0] : dir_q;
        seed_x_d     = seed_valid_d ? p0_q[5:0] : seed_x_q;
        seed_y_d     = seed_valid_d ? p1_q[5:0] : seed_y_q;
        link_cnt_d   = good ? '0 : link_cnt_q + LW'(link_cnt_q != LINK_LAST);
        con_error_d  = !good && (con_error_q || link_cnt_q == LINK_LAST);
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            type_q       <= '0;
            p0_q         <= '0;
            p1_q         <= '0;
            byte_cnt_q   <= '0;
            link_cnt_q   <= '0;
            dir_q        <= '0;
            seed_x_q     <= '0;
            seed_y_q     <= '0;
            dir_valid_q  <= 1'b0;
            seed_valid_q <= 1'b0;
            start_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            con_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            type_q       <= type_d;
            p0_q         <= p0_d;
            p1_q         <= p1_d;
            byte_cnt_q   <= byte_cnt_d;
            link_cnt_q   <= link_cnt_d;
            dir_q        <= dir_d;
            seed_x_q     <= seed_x_d;
            seed_y_q     <= seed_y_d;
            dir_valid_q  <= dir_valid_d;
            seed_valid_q <= seed_valid_d;
            start_q      <= start_d;
            frame_err_q  <= frame_err_d;
            con_error_q  <= con_error_d;
        end
    end
`ifdef LINK_STATS_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    always_comb err_cnt_d = frame_err_d && err_cnt_q != 8'hFF ? err_cnt_q + 8'd1 : err_cnt_q;
    always_ff @(posedge clk) err_cnt_q <= !rst ? 8'h00 : err_cnt_d;
    assign lnk.err_cnt = err_cnt_q;
`else
    assign lnk.err_cnt = 8'h00;
`endif
    assign lnk.dir_out    = dir_q;
    assign lnk.dir_valid  = dir_valid_q;
    assign lnk.seed_x     = seed_x_q;
    assign lnk.seed_y     = seed_y_q;
    assign lnk.seed_valid = seed_valid_q;
    assign lnk.start_game = start_q;
    assign lnk.frame_err  = frame_err_q;
    assign lnk.con_error  = con_error_q;
endmodule

// File: tb/tb_link_frame_rx.sv
// tb_link_frame_rx: table vectors, timeout corner sequences and random traffic
// checked every cycle against a frame-level reference model.
module tb_link_frame_rx;
    localparam int BT = 16;
    localparam int LT = 600;
    localparam logic [7:0] SYNC = 8'hA5;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    link_frame_rx_if lnk ();
    link_frame_rx #(.SYNC_BYTE(SYNC), .BYTE_TIMEOUT(BT), .LINK_TIMEOUT(LT)) dut (
        .clk(clk),
        .rst(rst),
        .lnk(lnk)
    );
    typedef struct {
        logic [0:6][7:0] b;
        int              n;
        logic [3:0]      stb;
        logic [1:0]      dir;
        logic [5:0]      sx;
        logic [5:0]      sy;
    } vec_t;
    vec_t vecs [9];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_byte = 0;
    int last_good = -1;
    int r;
    logic [7:0] fq [$];
    logic [7:0] bb, rt, rp0, rp1;
    logic [1:0] m_dir;
    logic [5:0] m_sx, m_sy;
    logic [7:0] m_ecnt;
    logic m_dv, m_sv, m_st, m_fe, m_con;
    function automatic logic [26:0] outs();
        return {lnk.dir_valid, lnk.seed_valid, lnk.start_game, lnk.frame_err, lnk.con_error,
                lnk.dir_out, lnk.seed_x, lnk.seed_y, lnk.err_cnt};
    endfunction
    function automatic logic [26:0] expv();
        return {m_dv, m_sv, m_st, m_fe, m_con, m_dir, m_sx, m_sy, m_ecnt};
    endfunction
    function automatic logic [3:0] stb();
        return {lnk.dir_valid, lnk.seed_valid, lnk.start_game, lnk.frame_err};
    endfunction
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h expected %h", name, cyc, act, exp);
        end
    endtask
    task automatic model_reset();
        fq.delete();
        {m_dv, m_sv, m_st, m_fe, m_con} = '0;
        m_dir = '0;
        m_sx = '0;
        m_sy = '0;
        m_ecnt = '0;
        last_good = cyc - 1;
    endtask
    // frame-level view: collect bytes after a sync, judge at five, drop on silence
    task automatic model_step(input logic v, input logic [7:0] d);
        logic [7:0] t, p0, p1, c;
        bit good;
        good = 0;
        {m_dv, m_sv, m_st, m_fe} = '0;
        if (v) begin
            if (fq.size() > 0 || d == SYNC) fq.push_back(d);
            last_byte = cyc;
            if (fq.size() == 5) begin
                t = fq[1];
                p0 = fq[2];
                p1 = fq[3];
                c = fq[4];
                if (c == (t ^ p0 ^ p1) && t >= 8'd1 && t <= 8'd3) begin
                    good = 1;
                    if (t == 8'd1) begin
                        m_dv = 1;
                        m_dir = p0[1:0];
                    end else if (t == 8'd2) begin
                        m_sv = 1;
                        m_sx = p0[5:0];
                        m_sy = p1[5:0];
                    end else m_st = 1;
                end else m_fe = 1;
                fq.delete();
            end
        end else if (fq.size() > 0 && cyc - last_byte == BT) begin
            fq.delete();
            m_fe = 1;
        end
        if (good) last_good = cyc;
        m_con = cyc - last_good >= LT;
`ifdef LINK_STATS_EN
        if (m_fe && m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
`endif
    endtask
    task automatic step(input logic v, input logic [7:0] d, input string name);
        lnk.rx_valid = v;
        lnk.rx_data = d;
        model_step(v, d);
        @(posedge clk);
        #1;
        cyc++;
        check(name, 32'(outs()), 32'(expv()));
        lnk.rx_valid = 1'b0;
    endtask
    task automatic do_reset();
        rst = 1'b0;
        lnk.rx_valid = 1'b0;
        lnk.rx_data = 8'h00;
        @(posedge clk);
        #1;
        cyc++;
        model_reset();
        check("reset_vals", 32'(outs()), 32'h0);
        rst = 1'b1;
    endtask
    task automatic idle(input int n, input string name);
        repeat (n) step(1'b0, 8'h00, name);
    endtask
    task automatic send(input logic [7:0] t, p0, p1, c, input bit gaps, input string name);
        logic [7:0] fb [5];
        fb = '{SYNC, t, p0, p1, c};
        for (int i = 0; i < 5; i++) begin
            if (gaps && i > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(0, BT + 1), "rnd_gap");
            step(1'b1, fb[i], name);
        end
    endtask
    initial begin
        #5_000_000;
        $display("FAIL watchdog cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
    initial begin
        lnk.rx_valid = 1'b0;
        lnk.rx_data = 8'h00;
        vecs[0] = '{b: {8'hA5, 8'h01, 8'h02, 8'h00, 8'h03, 8'h00, 8'h00}, n: 5, stb: 4'b1000, dir: 2'd2, sx: 6'h00, sy: 6'h00};
        vecs[1] = '{b: {8'hA5, 8'h02, 8'h15, 8'h2A, 8'h3D, 8'h00, 8'h00}, n: 5, stb: 4'b0100, dir: 2'd2, sx: 6'h15, sy: 6'h2A};
        vecs[2] = '{b: {8'h00, 8'hFF, 8'hA5, 8'h03, 8'h00, 8'h00, 8'h03}, n: 7, stb: 4'b0010, dir: 2'd2, sx: 6'h15, sy: 6'h2A};
        vecs[3] = '{b: {8'hA5, 8'h01, 8'h02, 8'h00, 8'h04, 8'h00, 8'h00}, n: 5, stb: 4'b0001, dir: 2'd2, sx: 6'h15, sy: 6'h2A};
        vecs[4] = '{b: {8'hA5, 8'h04, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00}, n: 5, stb: 4'b0001, dir: 2'd2, sx: 6'h15, sy: 6'h2A};
        vecs[5] = '{b: {8'hA5, 8'hA5, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00}, n: 5, stb: 4'b0001, dir: 2'd2, sx: 6'h15, sy: 6'h2A};
        vecs[6] = '{b: {8'hA5, 8'h01, 8'h07, 8'h00, 8'h06, 8'h00, 8'h00}, n: 5, stb: 4'b1000, dir: 2'd3, sx: 6'h15, sy: 6'h2A};
        vecs[7] = '{b: {8'hA5, 8'h02, 8'hFF, 8'hC1, 8'h3C, 8'h00, 8'h00}, n: 5, stb: 4'b0100, dir: 2'd3, sx: 6'h3F, sy: 6'h01};
        vecs[8] = '{b: {8'hA5, 8'h02, 8'h15, 8'h2A, 8'h3C, 8'h00, 8'h00}, n: 5, stb: 4'b0001, dir: 2'd3, sx: 6'h3F, sy: 6'h01};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < vecs[i].n; j++) begin
                bb = vecs[i].b[j];
                step(1'b1, bb, "vec_byte");
                if (j < vecs[i].n - 1) check("vec_quiet", 32'(stb()), 32'h0);
            end
            check("vec_result", 32'({stb(), lnk.dir_out, lnk.seed_x, lnk.seed_y}),
                  32'({vecs[i].stb, vecs[i].dir, vecs[i].sx, vecs[i].sy}));
            step(1'b0, 8'h00, "vec_gap");
            check("vec_one_cycle", 32'(stb()), 32'h0);
        end
        step(1'b1, SYNC, "bto");
        step(1'b1, 8'h01, "bto");
        idle(BT - 1, "bto_wait");
        check("bto_early", 32'(lnk.frame_err), 32'h0);
        step(1'b0, 8'h00, "bto_fire");
        check("bto_err", 32'(lnk.frame_err), 32'h1);
        send(8'h01, 8'h01, 8'h00, 8'h00, 1'b0, "bto_after");
        check("bto_after_dir", 32'({lnk.dir_valid, lnk.dir_out}), 32'({1'b1, 2'd1}));
        step(1'b1, SYNC, "race");
        step(1'b1, 8'h01, "race");
        idle(BT - 1, "race_wait");
        step(1'b1, 8'h02, "race_byte");
        check("race_no_err", 32'(lnk.frame_err), 32'h0);
        step(1'b1, 8'h00, "race");
        step(1'b1, 8'h03, "race_chk");
        check("race_dir", 32'({lnk.dir_valid, lnk.dir_out}), 32'({1'b1, 2'd2}));
        repeat (150) begin
            r = $urandom_range(0, 9);
            rt = 8'($urandom_range(1, 3));
            rp0 = 8'($urandom);
            rp1 = 8'($urandom);
            if (r < 5) send(rt, rp0, rp1, rt ^ rp0 ^ rp1, 1'b1, "rnd_good");
            else if (r < 7) send(rt, rp0, rp1, ~(rt ^ rp0 ^ rp1), 1'b1, "rnd_badchk");
            else if (r == 7) step(1'b1, 8'($urandom), "rnd_junk");
            else if (r == 8) idle($urandom_range(0, LT + 50), "rnd_quiet");
            else send(8'h80 | rp1, rp0, rp1, 8'h80 | rp0, 1'b1, "rnd_badtype");
        end
        do_reset();
        idle(LT - 1, "lto_wait");
        check("lto_early", 32'(lnk.con_error), 32'h0);
        step(1'b0, 8'h00, "lto_fire");
        check("lto_set", 32'(lnk.con_error), 32'h1);
        step(1'b1, SYNC, "lto_start");
        step(1'b1, 8'h03, "lto_start");
        step(1'b1, 8'h00, "lto_start");
        step(1'b1, 8'h00, "lto_start");
        check("lto_held", 32'(lnk.con_error), 32'h1);
        step(1'b1, 8'h03, "lto_start_chk");
        check("lto_clear", 32'({lnk.start_game, lnk.con_error}), 32'b10);
        do_reset();
        idle(LT - 5, "lrace_wait");
        send(8'h01, 8'h03, 8'h00, 8'h02, 1'b0, "lrace");
        check("lrace_good", 32'({lnk.dir_valid, lnk.con_error, lnk.dir_out}), 32'({1'b1, 1'b0, 2'd3}));
        idle(3, "lrace_after");
        check("lrace_quiet", 32'(lnk.con_error), 32'h0);
        step(1'b1, SYNC, "mid");
        step(1'b1, 8'h01, "mid");
        step(1'b1, 8'h02, "mid");
        do_reset();
        step(1'b1, 8'h00, "mid_tail");
        step(1'b1, 8'h03, "mid_tail");
        check("mid_no_strobe", 32'({stb(), lnk.dir_out}), 32'h0);
        idle(BT + 2, "mid_idle");
        check("mid_no_late_err", 32'(lnk.frame_err), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
